// File: rtl/i2s_transmitter_pkg.sv
// i2s_transmitter_pkg: default I2S framing constants and a counter-width helper
package i2s_transmitter_pkg;
    localparam int I2S_WIDTH     = 24;
    localparam int I2S_SLOT_BITS = 32;
    localparam int I2S_BCLK_DIV  = 4;

    function automatic int bits_for(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/i2s_transmitter_clock_gen.sv
// i2s_clock_gen: bit-clock divider and frame bit counter; everything parks at zero while run is low
module i2s_clock_gen
    import i2s_transmitter_pkg::*;
#(
    parameter int SLOT_BITS = I2S_SLOT_BITS,
    parameter int BCLK_DIV  = I2S_BCLK_DIV,
    parameter int BW        = bits_for(2 * SLOT_BITS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    output logic          bclk,
    output logic [BW-1:0] b,
    output logic          bit_start,
    output logic          wrap
);
    localparam int DW = bits_for(BCLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic [BW-1:0] b_q, b_d;
    logic          half_end;

    // bit_start and wrap flag the edge that begins the next bit / next frame
    always_comb begin
        half_end  = div_q == DW'(BCLK_DIV - 1);
        bit_start = run && half_end && bclk_q;
        wrap      = bit_start && b_q == BW'(2 * SLOT_BITS - 1);
        div_d     = run && !half_end ? div_q + 1'b1 : '0;
        bclk_d    = run && (bclk_q ^ half_end);
        b_d       = !run || wrap ? '0 : b_q + BW'(bit_start);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            b_q    <= '0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            b_q    <= b_d;
        end
    end

    assign bclk = bclk_q;
    assign b    = b_q;
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: mono sample stream to Philips I2S master, one-deep pending buffer,
// same sample on both slots, drain-then-stop on enable low
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int WIDTH     = I2S_WIDTH,
    parameter int SLOT_BITS = I2S_SLOT_BITS,
    parameter int BCLK_DIV  = I2S_BCLK_DIV
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             frame_start,
    output logic             underrun
);
    localparam int          BW  = bits_for(2 * SLOT_BITS);
    localparam int          IW  = bits_for(WIDTH);
    localparam logic [31:0] SB  = SLOT_BITS;
    localparam logic [31:0] W32 = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d, frame_q, frame_d;
    logic             pend_v_q, pend_v_d;
    logic             lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic             fs_q, fs_d, ur_q, ur_d;
    logic             run, bit_start, wrap, load, accept;
    logic [BW-1:0]    b, nb;
    logic [31:0]      pos;
    logic [IW-1:0]    idx;

    assign run = state_q != IDLE;

    i2s_clock_gen #(.SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV), .BW(BW)) u_clock_gen (
        .clk(clk), .rstn(rstn), .run(run),
        .bclk(bclk), .b(b), .bit_start(bit_start), .wrap(wrap)
    );

    always_comb begin
        state_d  = state_q == IDLE ? (enable ? RUN : IDLE)
                 : enable ? RUN : state_q == RUN ? DRAIN : wrap ? IDLE : DRAIN;
        load     = state_q == IDLE ? enable : wrap && (state_q == RUN || enable);
        in_ready = !pend_v_q || load;
        accept   = in_valid && in_ready;
        pend_d   = accept ? in : pend_q;
        pend_v_d = accept || (pend_v_q && !load);
        frame_d  = load ? (pend_v_q ? pend_q : '0) : frame_q;
        fs_d     = load;
        ur_d     = load && !pend_v_q;
        // outputs are registered, so they are computed for the bit about to start
        nb       = wrap ? '0 : b + BW'(bit_start);
        lrclk_d  = 32'(nb) >= SB;
        pos      = lrclk_d ? 32'(nb) - SB : 32'(nb);
        idx      = IW'(W32 - pos);
        sdata_d  = pos != 0 && pos <= W32 && frame_d[idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            frame_q  <= '0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            fs_q     <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            frame_q  <= frame_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            fs_q     <= fs_d;
            ur_q     <= ur_d;
        end
    end

    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: randomized stimulus against a frame-time reference model of the I2S transmitter
module tb_i2s_transmitter;
    localparam int W = 24;
    localparam int S = 32;
    localparam int D = 2;
    localparam int F = 4 * S * D;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         enable = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         in_ready, bclk, lrclk, sdata, frame_start, underrun;

    always #5 clk = ~clk;

    i2s_transmitter #(.WIDTH(W), .SLOT_BITS(S), .BCLK_DIV(D)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .in(din), .bclk(bclk), .lrclk(lrclk),
        .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: m_t is the clk cycle within the current frame while active
    bit           m_act, m_drain, m_pv, m_fs, m_ur;
    int           m_t;
    logic [W-1:0] m_pend, m_frame;
    bit           last_acc;

    function automatic bit m_load();
        return !m_act ? enable : (m_t == F - 1 && (!m_drain || enable));
    endfunction

    task automatic m_reset();
        m_act = 0; m_drain = 0; m_pv = 0; m_fs = 0; m_ur = 0;
        m_t = 0; m_pend = '0; m_frame = '0;
    endtask

    task automatic m_step();
        bit ld, acc, fin;
        ld  = m_load();
        acc = in_valid && (!m_pv || ld);
        fin = m_act && m_t == F - 1 && m_drain && !enable;
        m_fs = ld;
        m_ur = ld && !m_pv;
        if (ld) m_frame = m_pv ? m_pend : '0;
        if (acc) begin
            m_pend = din;
            m_pv = 1;
        end else if (ld) m_pv = 0;
        if (!m_act) begin
            m_act = enable;
            m_t = 0;
        end else begin
            m_t = (m_t + 1) % F;
            if (fin) m_act = 0;
        end
        m_drain = !enable;
    endtask

    task automatic chk_out();
        int bi, p;
        logic e_bclk, e_lr, e_sd;
        e_bclk = 0; e_lr = 0; e_sd = 0;
        if (m_act) begin
            bi = m_t / (2 * D);
            e_bclk = (m_t % (2 * D)) >= D;
            e_lr = bi >= S;
            p = bi % S;
            e_sd = (p >= 1 && p <= W) ? m_frame[W-p] : 1'b0;
        end
        chk("bclk", bclk, e_bclk);
        chk("lrclk", lrclk, e_lr);
        chk("sdata", sdata, e_sd);
        chk("frame_start", frame_start, m_fs);
        chk("underrun", underrun, m_ur);
    endtask

    bit          col_en = 0;
    int          col_k = 0;
    int          lr_hi = 0;
    logic [31:0] wl = '0, wr = '0;
    logic        pb = 1'b0;

    task automatic step();
        bit r;
        #1;
        r = !m_pv || m_load();
        if (rstn) chk("in_ready", in_ready, r);
        else chk("in_ready_rst", in_ready, 1);
        last_acc = rstn && in_valid && r;
        @(posedge clk);
        if (rstn) m_step();
        else m_reset();
        #1;
        chk_out();
        if (col_en) begin
            if (bclk && !pb) begin
                if (col_k < 32) wl = {wl[30:0], sdata};
                else if (col_k < 64) wr = {wr[30:0], sdata};
                col_k++;
            end
            if (lrclk) lr_hi++;
        end
        pb = bclk;
    endtask

    task automatic async_rst();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ur", underrun, 0);
        chk("rst_ready", in_ready, 1);
        m_reset();
        in_valid = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
    endtask

    initial begin
        int k, rate, len, mode;
        logic [W-1:0] vals[3];
        m_reset();
        repeat (3) step();
        rstn = 1'b1;

        // sample 800001 written while idle goes out in the first frame
        in_valid = 1'b1;
        din = 24'h800001;
        step();
        in_valid = 1'b0;
        enable = 1'b1;
        col_en = 1;
        repeat (F) step();
        col_en = 0;
        chk("word_left", wl, 32'h4000_0080);
        chk("word_right", wr, 32'h4000_0080);
        chk("lr_high_cycles", lr_hi, F / 2);
        chk("bclk_rises", col_k, 2 * S);

        // three back-to-back samples
        for (int i = 0; i < 3; i++) vals[i] = W'($urandom);
        k = 0;
        for (int i = 0; i < 3 * F && k < 3; i++) begin
            in_valid = 1'b1;
            din = vals[k];
            step();
            if (last_acc) k++;
        end
        in_valid = 1'b0;
        chk("abc_accepted", k, 3);
        repeat (3 * F) step();

        // reset in the middle of bit 40, then restart with nothing pending
        in_valid = 1'b1;
        din = W'($urandom) | 24'hFFFF00;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2 * F && !(m_act && m_t == 40 * 2 * D + 1); i++) step();
        chk("reach_b40", m_act && m_t == 40 * 2 * D + 1, 1);
        async_rst();
        repeat (F + 20) step();

        // disable at bit 10, drain, then stay idle
        for (int i = 0; i < 2 * F && !(m_act && m_t == 10 * 2 * D); i++) step();
        chk("reach_b10", m_act && m_t == 10 * 2 * D, 1);
        enable = 1'b0;
        repeat (F + 40) step();
        chk("idle_after_drain", m_act, 0);

        for (int seg = 0; seg < 30; seg++) begin
            mode = $urandom_range(0, 9);
            if (mode == 9) async_rst();
            else begin
                enable = mode < 6;
                rate = $urandom_range(0, 100);
                len = $urandom_range(20, 700);
                for (int i = 0; i < len; i++) begin
                    in_valid = $urandom_range(0, 99) < rate;
                    din = W'($urandom);
                    step();
                end
            end
        end
        in_valid = 1'b0;
        enable = 1'b0;
        repeat (F + 20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
